// File: rtl/decrypt_host_master.sv
// Avalon-MM host that pushes a ciphertext block and key into the decrypt slave
// (8 writes), reads back the plaintext (4 reads) and aborts on waitrequest timeout.
module decrypt_host_master #(
  parameter int unsigned WAIT_LIMIT = 1024
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [127:0] data_in,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic [127:0] data_out,
  output logic         address,
  output logic         write,
  output logic [31:0]  writedata,
  output logic         read,
  input  logic [31:0]  readdata,
  input  logic         waitrequest
);

  localparam int unsigned WCW = $clog2(WAIT_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, WRITE, READ, FINISH} state_t;

  state_t             state, state_n;
  logic [2:0]         idx, idx_n;
  logic [WCW-1:0]     wait_cnt, wait_n;
  logic [7:0][31:0]   words, words_n;
  logic [95:0]        rbuf, rbuf_n;
  logic               address_n, write_n, read_n, busy_n, done_n, error_n;
  logic [31:0]        writedata_n;
  logic [127:0]       data_out_n;

  // State and all registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      wait_cnt  <= '0;
      words     <= '0;
      rbuf      <= '0;
      address   <= 1'b0;
      write     <= 1'b0;
      read      <= 1'b0;
      writedata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      data_out  <= '0;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      wait_cnt  <= wait_n;
      words     <= words_n;
      rbuf      <= rbuf_n;
      address   <= address_n;
      write     <= write_n;
      read      <= read_n;
      writedata <= writedata_n;
      busy      <= busy_n;
      done      <= done_n;
      error     <= error_n;
      data_out  <= data_out_n;
    end
  end

  // Next-state and next-output logic; bus signals hold while stalled
  always_comb begin
    state_n     = state;
    idx_n       = idx;
    wait_n      = wait_cnt;
    words_n     = words;
    rbuf_n      = rbuf;
    address_n   = address;
    write_n     = write;
    read_n      = read;
    writedata_n = writedata;
    busy_n      = busy;
    done_n      = 1'b0;
    error_n     = 1'b0;
    data_out_n  = data_out;

    case (state)
      IDLE: begin
        address_n   = 1'b0;
        write_n     = 1'b0;
        read_n      = 1'b0;
        writedata_n = '0;
        busy_n      = 1'b0;
        if (start) begin
          words_n     = {key_in, data_in};
          idx_n       = '0;
          wait_n      = '0;
          state_n     = WRITE;
          busy_n      = 1'b1;
          write_n     = 1'b1;
          address_n   = 1'b1;
          writedata_n = data_in[31:0];
        end
      end

      WRITE, READ: begin
        if (waitrequest) begin
          if (wait_cnt == WCW'(WAIT_LIMIT - 1)) begin
            // Slave stuck: drop the strobe and report the abort
            address_n   = 1'b0;
            write_n     = 1'b0;
            read_n      = 1'b0;
            writedata_n = '0;
            wait_n      = '0;
            state_n     = FINISH;
            done_n      = 1'b1;
            error_n     = 1'b1;
          end else begin
            wait_n = WCW'(wait_cnt + WCW'(1));
          end
        end else begin
          wait_n = '0;
          if (state == WRITE) begin
            if (idx == 3'd7) begin
              idx_n       = '0;
              state_n     = READ;
              write_n     = 1'b0;
              writedata_n = '0;
              read_n      = 1'b1;
              address_n   = 1'b0;
            end else begin
              idx_n       = 3'(idx + 3'd1);
              writedata_n = words[3'(idx + 3'd1)];
            end
          end else begin
            if (idx == 3'd3) begin
              data_out_n = {readdata, rbuf};
              idx_n      = '0;
              state_n    = FINISH;
              read_n     = 1'b0;
              address_n  = 1'b0;
              done_n     = 1'b1;
            end else begin
              // Shift in from the top so word 0 ends up least significant
              rbuf_n = {readdata, rbuf[95:32]};
              idx_n  = 3'(idx + 3'd1);
            end
          end
        end
      end

      FINISH: begin
        busy_n  = 1'b0;
        state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_decrypt_host_master.sv
// Directed bench for decrypt_host_master with a small Avalon slave model.
module tb_decrypt_host_master;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [127:0] data_in, key_in;
  logic         busy, done, error;
  logic [127:0] data_out;
  logic         address, write, read, waitrequest;
  logic [31:0]  writedata, readdata;

  int checks = 0;
  int fails  = 0;

  decrypt_host_master #(.WAIT_LIMIT(8)) dut (
    .clk(clk), .reset(reset), .start(start), .data_in(data_in), .key_in(key_in),
    .busy(busy), .done(done), .error(error), .data_out(data_out),
    .address(address), .write(write), .writedata(writedata), .read(read),
    .readdata(readdata), .waitrequest(waitrequest)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] D0   = 128'h91f025e0_e7734057_0cf1931a_70918058;
  localparam logic [127:0] K0   = 128'h12345678_9abcdef0_aabbccdd_eeff0011;
  localparam logic [127:0] DOUT = 128'h44444444_33333333_22222222_11111111;

  // Slave stall plan, written only by the initial block
  int stall_wr = -1, stall_rd = -1, stall_len = 0, stuck_wr = -1;

  // Monitor state, written only by the monitor
  logic [31:0] wr_log [8];
  int wr_cnt = 0, rd_cnt = 0, cyc = 0, done_cnt = 0, done_cyc = 0;
  int st_cnt = 0, stab_err = 0, addr_err = 0;
  logic done_err = 1'b0;
  logic [34:0] prev_sig = '0;
  logic prev_stall = 1'b0;

  always_comb begin
    case (rd_cnt)
      0: readdata = 32'h11111111;
      1: readdata = 32'h22222222;
      2: readdata = 32'h33333333;
      default: readdata = 32'h44444444;
    endcase
  end

  always_comb begin
    waitrequest = 1'b0;
    if (write && stuck_wr >= 0 && wr_cnt >= stuck_wr) waitrequest = 1'b1;
    if (write && wr_cnt == stall_wr && st_cnt < stall_len) waitrequest = 1'b1;
    if (read && rd_cnt == stall_rd && st_cnt < stall_len) waitrequest = 1'b1;
  end

  // Transfer log, stall stability and done timing, cleared at each accepted start
  always @(posedge clk) begin
    prev_sig   <= {address, write, read, writedata};
    prev_stall <= (write || read) && waitrequest;
    if (start && !busy && !reset) begin
      wr_cnt <= 0; rd_cnt <= 0; cyc <= 0; done_cnt <= 0; done_cyc <= 0;
      st_cnt <= 0; stab_err <= 0; addr_err <= 0;
    end else begin
      cyc <= cyc + 1;
      if (reset) st_cnt <= 0;
      else if ((write || read) && waitrequest) st_cnt <= st_cnt + 1;
      else if (write || read) st_cnt <= 0;
      if (prev_stall && ({address, write, read, writedata} != prev_sig)) stab_err <= stab_err + 1;
      if (write && read) stab_err <= stab_err + 1;
      if (write && !waitrequest) begin
        if (wr_cnt < 8) wr_log[wr_cnt] <= writedata;
        if (address !== 1'b1) addr_err <= addr_err + 1;
        wr_cnt <= wr_cnt + 1;
      end
      if (read && !waitrequest) begin
        if (address !== 1'b0) addr_err <= addr_err + 1;
        rd_cnt <= rd_cnt + 1;
      end
      if (done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc + 1;
        done_err <= error;
      end
    end
  end

  task automatic run_job(input logic [127:0] d, input logic [127:0] k, input bit extra);
    int n;
    @(negedge clk);
    data_in = d; key_in = k; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      if (extra && (n == 2 || n == 10)) begin
        start = 1'b1; data_in = ~d; key_in = ~k;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0; data_in = d; key_in = k;
    if (done !== 1'b1) begin
      checks++; fails++;
      $display("FAIL job_wait: done=%b not seen within 100 cycles", done);
    end
    @(negedge clk);
  endtask

  task automatic check_writes(input logic [127:0] d, input logic [127:0] k);
    logic [7:0][31:0] exp;
    exp = {k, d};
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (wr_log[i] !== exp[i]) begin
        fails++;
        $display("FAIL writedata[%0d]: got %h want %h", i, wr_log[i], exp[i]);
      end
    end
    checks++;
    if (addr_err !== 0 || stab_err !== 0) begin
      fails++;
      $display("FAIL bus_protocol: addr_err=%0d stab_err=%0d want 0/0", addr_err, stab_err);
    end
  endtask

  task automatic check_result(input string name, input int exp_cyc, input logic exp_err,
                              input logic [127:0] exp_dout);
    checks++;
    if (done_cyc !== exp_cyc || done_cnt !== 1) begin
      fails++;
      $display("FAIL %s_done: cycle=%0d count=%0d want cycle=%0d count=1", name, done_cyc, done_cnt, exp_cyc);
    end
    checks++;
    if (done_err !== exp_err) begin
      fails++;
      $display("FAIL %s_error: got %b want %b", name, done_err, exp_err);
    end
    checks++;
    if (data_out !== exp_dout) begin
      fails++;
      $display("FAIL %s_data_out: got %h want %h", name, data_out, exp_dout);
    end
    checks++;
    if (busy !== 1'b0 || write !== 1'b0 || read !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL %s_idle: busy=%b write=%b read=%b done=%b want 0000", name, busy, write, read, done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; data_in = D0; key_in = K0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, error, write, read, address} !== 6'b0 || writedata !== 32'h0 || data_out !== 128'h0) begin
      fails++;
      $display("FAIL reset_state: busy=%b done=%b error=%b write=%b read=%b addr=%b wd=%h dout=%h want all 0",
               busy, done, error, write, read, address, writedata, data_out);
    end
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || write !== 1'b0) begin
      fails++;
      $display("FAIL start_with_reset: busy=%b write=%b want 0/0", busy, write);
    end
  endtask

  task automatic test_zero_wait();
    run_job(D0, K0, 1'b0);
    check_writes(D0, K0);
    check_result("zero_wait", 13, 1'b0, DOUT);
    checks++;
    if (rd_cnt !== 4) begin
      fails++;
      $display("FAIL zero_wait_reads: got %0d want 4", rd_cnt);
    end
  endtask

  task automatic test_stalls();
    stall_wr = 1; stall_rd = 0; stall_len = 3;
    run_job(K0, D0, 1'b0);
    check_writes(K0, D0);
    check_result("stalls", 19, 1'b0, DOUT);
    stall_wr = -1; stall_rd = -1; stall_len = 0;
  endtask

  task automatic test_wait_clear();
    // Two 6-cycle stalls exceed the limit only if the counter fails to clear
    stall_wr = 6; stall_rd = 2; stall_len = 6;
    run_job(D0, K0, 1'b0);
    check_result("wait_clear", 25, 1'b0, DOUT);
    stall_wr = -1; stall_rd = -1; stall_len = 0;
  endtask

  task automatic test_timeout();
    stuck_wr = 4;
    run_job(~D0, ~K0, 1'b0);
    check_result("timeout", 13, 1'b1, DOUT);
    checks++;
    if (wr_cnt !== 4 || rd_cnt !== 0) begin
      fails++;
      $display("FAIL timeout_xfers: writes=%0d reads=%0d want 4/0", wr_cnt, rd_cnt);
    end
    stuck_wr = -1;
  endtask

  task automatic test_busy_start();
    run_job(D0, K0, 1'b1);
    check_writes(D0, K0);
    check_result("busy_start", 13, 1'b0, DOUT);
    checks++;
    if (wr_cnt !== 8 || rd_cnt !== 4) begin
      fails++;
      $display("FAIL busy_start_xfers: writes=%0d reads=%0d want 8/4", wr_cnt, rd_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    @(negedge clk);
    data_in = D0; key_in = K0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (read !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (read !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_reach_read: read=%b want 1", read);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (busy !== 1'b0 || read !== 1'b0 || done !== 1'b0 || data_out !== 128'h0) begin
      fails++;
      $display("FAIL reset_mid_state: busy=%b read=%b done=%b dout=%h want 0/0/0/0", busy, read, done, data_out);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (done_cnt !== 0) begin
      fails++;
      $display("FAIL reset_mid_no_done: done pulses=%0d want 0", done_cnt);
    end
    run_job(D0, K0, 1'b0);
    check_result("after_reset", 13, 1'b0, DOUT);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; data_in = '0; key_in = '0;
    test_reset();
    test_zero_wait();
    test_stalls();
    test_wait_clear();
    test_timeout();
    test_busy_start();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
    $finish;
  end

endmodule

// File: doc/decrypt_host_master.md
DECRYPT_HOST_MASTER -- requirements
Module: decrypt_host_master

Interface
REQ-001 SHALL have parameter WAIT_LIMIT, default 1024, giving the maximum consecutive waitrequest-stalled cycles per bus transfer before abort.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port start, input, 1, a one-cycle request to run one decrypt job.
REQ-005 SHALL have port data_in, input, 128, ciphertext block.
REQ-006 SHALL have port key_in, input, 128, key.
REQ-007 SHALL have port busy, output, 1, high while a job is in progress.
REQ-008 SHALL have port done, output, 1, a one-cycle job-completion pulse.
REQ-009 SHALL have port error, output, 1, valid with done; 1 means the job was aborted by timeout.
REQ-010 SHALL have port data_out, output, 128, decrypted block.
REQ-011 SHALL have Avalon-MM master ports address (output, 1), write (output, 1), writedata (output, 32), read (output, 1), readdata (input, 32) and waitrequest (input, 1), connected to the decrypt slave.

Function
REQ-012 SHALL implement FSM states IDLE, WRITE, READ, FINISH.
REQ-013 In IDLE, start=1 SHALL capture data_in and key_in into internal registers, clear the word index, and move to WRITE; busy rises in the next cycle.
REQ-014 start SHALL be ignored while busy=1.
REQ-015 WRITE SHALL issue 8 writes with address=1: data_in[31:0], [63:32], [95:64], [127:96], then key_in[31:0], [63:32], [95:64], [127:96].
REQ-016 A transfer SHALL complete on an edge where (write or read)=1 and waitrequest=0.
REQ-017 While waitrequest=1, address, write, read and writedata SHALL remain stable.
REQ-018 write and read SHALL never be asserted together.
REQ-019 After the 8th write completes, the FSM SHALL enter READ.
REQ-020 READ SHALL issue 4 reads with address=0, with zero read latency: readdata is captured on the completing edge.
REQ-021 Read words SHALL be stored least significant first into data_out[31:0] .. [127:96].
REQ-022 After the 4th read completes, the FSM SHALL enter FINISH.
REQ-023 FINISH SHALL assert done=1 and error=0 for exactly one cycle, then return to IDLE with busy=0.
REQ-024 data_out SHALL be updated only at successful completion and SHALL hold its value until the next successful job.
REQ-025 With waitrequest held at 0, write SHALL be high for the 8 cycles after the start edge and read for the following 4 cycles; done SHALL be high in the 13th cycle after the start edge.
REQ-026 A wait counter SHALL count consecutive cycles with a pending transfer and waitrequest=1, and SHALL clear on every completed transfer.
REQ-027 When the wait counter reaches WAIT_LIMIT, the block SHALL deassert write/read and go to FINISH with error=1; data_out is unchanged.
REQ-028 In IDLE, address, write, read and writedata SHALL all be 0.

Reset
REQ-029 On reset=1 at a clock edge, the block SHALL go to IDLE, and busy, done, error, write, read, address, writedata, data_out and the counters SHALL all be 0.
REQ-030 Reset mid-job SHALL abort without a done pulse, and bus strobes SHALL be low in the cycle after the reset edge.
REQ-031 start asserted together with reset SHALL be ignored.

Verification
REQ-032 Bench SHALL cover these directed scenarios:
- Zero-wait job: data_in=0x91f025e0_e7734057_0cf1931a_70918058, key_in=0x12345678_9abcdef0_aabbccdd_eeff0011 -> writedata sequence 70918058, 0cf1931a, e7734057, 91f025e0, eeff0011, aabbccdd, 9abcdef0, 12345678 at address 1; slave model returns 0x11111111, 0x22222222, 0x33333333, 0x44444444 -> data_out=0x44444444_33333333_22222222_11111111, done in cycle 13, error=0.
- Stalls: waitrequest=1 for 3 cycles on write #2 and read #1 -> signals held stable during stalls, same data_out, done 6 cycles later than zero-wait.
- Timeout: WAIT_LIMIT=8, waitrequest stuck at 1 from write #5 -> done=1 and error=1 after 8 stalled cycles, strobes low, previous data_out kept.
- start pulsed while busy -> ignored; exactly one done pulse and 12 transfers.
- Reset asserted during READ -> the next cycle shows busy=0, read=0, data_out=0, no done; a following job completes normally.
